uart_tx_ctrl: RTL and testbench

Frame controller for the UART transmitter.
- Accepts a parallel word on a valid/busy handshake and computes its parity.
- Sequences the frame: start bit, DATA_WIDTH data bits, optional parity bit, one or two stop bits.
- Drives the serializer shift enable and selects the line value for TX_OUT, one bit per CLK cycle.
- Sits between the upstream data source and the serializer; TX_OUT is the UART TX line.

---
 rtl/uart_tx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : Frame controller for a UART transmitter. Accepts a parallel
//               word on a valid/busy handshake, computes its parity, and
//               sequences start, data (LSB first), optional parity and one or
//               two stop bits, one bit per clock. Drives the serializer shift
//               enable and the line-select / line value for TX_OUT.
//
// Ports       : CLK        - system clock, one UART bit time per cycle
//               RST        - asynchronous reset, active-high
//               P_DATA     - parallel word, sampled on accept
//               Data_Valid - upstream word valid
//               PAR_EN     - 1 = insert parity bit (sampled on accept)
//               PAR_TYP    - 0 = even, 1 = odd (sampled on accept)
//               STOP2      - 1 = two stop bits (sampled on accept)
//               Ser_data   - current LSB presented by the serializer
//               Ser_EN     - serializer shift enable (DATA state only)
//               Busy       - frame in progress
//               TX_OUT     - UART line
//               Mux_sel    - line select: 00 start, 01 stop/idle,
//                            10 data, 11 parity
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  Ser_data,
    output logic                  Ser_EN,
    output logic                  Busy,
    output logic                  TX_OUT,
    output logic [1:0]            Mux_sel
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP1  = 3'd4;
    localparam logic [2:0] c_ST_STOP2  = 3'd5;

    // Line-select encoding
    localparam logic [1:0] c_SEL_START  = 2'b00;
    localparam logic [1:0] c_SEL_STOP   = 2'b01;
    localparam logic [1:0] c_SEL_DATA   = 2'b10;
    localparam logic [1:0] c_SEL_PARITY = 2'b11;

    // Counter value on the last data bit of a frame
    localparam logic [CNT_WIDTH-1:0] c_LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [CNT_WIDTH-1:0] r_bit_cnt;
    logic                 r_par_en;
    logic                 r_stop2;
    // Holds the transmitted parity bit; the even/odd choice is folded in at
    // accept time, so the parity type needs no separate storage afterwards.
    logic                 r_parity;

    // ------------------------------------------------------------------------
    // Combinational next-state signals
    // ------------------------------------------------------------------------
    logic [2:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_accept;

    assign w_accept = (r_state == c_ST_IDLE) && Data_Valid;

    // ------------------------------------------------------------------------
    // State, counter and frame configuration registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= c_ST_IDLE;
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
            r_stop2   <= 1'b0;
            r_parity  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            // Configuration is captured only on accept so that changes on
            // the inputs while a frame is in flight cannot disturb it.
            if (w_accept) begin
                r_par_en <= PAR_EN;
                r_stop2  <= STOP2;
                r_parity <= (^P_DATA) ^ PAR_TYP;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (Data_Valid) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                w_state_nxt = c_ST_DATA;
                w_cnt_nxt   = '0;
            end
            c_ST_DATA: begin
                if (r_bit_cnt == c_LAST_BIT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_par_en ? c_ST_PARITY : c_ST_STOP1;
                end else begin
                    w_cnt_nxt   = r_bit_cnt + CNT_WIDTH'(1);
                end
            end
            c_ST_PARITY: begin
                w_state_nxt = c_ST_STOP1;
            end
            c_ST_STOP1: begin
                w_state_nxt = r_stop2 ? c_ST_STOP2 : c_ST_IDLE;
            end
            c_ST_STOP2: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                // Unused encodings recover to IDLE
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (registered state only, plus the serializer LSB in DATA)
    // ------------------------------------------------------------------------
    always_comb begin
        Busy    = 1'b1;
        Ser_EN  = 1'b0;
        Mux_sel = c_SEL_STOP;
        TX_OUT  = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                Busy = 1'b0;
            end
            c_ST_START: begin
                Mux_sel = c_SEL_START;
                TX_OUT  = 1'b0;
            end
            c_ST_DATA: begin
                Mux_sel = c_SEL_DATA;
                TX_OUT  = Ser_data;
                Ser_EN  = 1'b1;
            end
            c_ST_PARITY: begin
                Mux_sel = c_SEL_PARITY;
                TX_OUT  = r_parity;
            end
            c_ST_STOP1, c_ST_STOP2: begin
                Mux_sel = c_SEL_STOP;
                TX_OUT  = 1'b1;
            end
            default: begin
                // Unused encodings look idle on the line for their one cycle
                Busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Self-checking bench for uart_tx_ctrl. A small serializer
//               model feeds Ser_data; expected line cycles are built from the
//               frame format (start, data LSB first, parity, stops, idle).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic       Ser_data;
    logic       Ser_EN;
    logic       Busy;
    logic       TX_OUT;
    logic [1:0] Mux_sel;

    int checks = 0;
    int errors = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Ser_data   (Ser_data),
        .Ser_EN     (Ser_EN),
        .Busy       (Busy),
        .TX_OUT     (TX_OUT),
        .Mux_sel    (Mux_sel)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer model: loads the word on the handshake, shifts right on Ser_EN
    logic [7:0] r_ser;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    r_ser <= 8'h00;
        else if (!Busy && Data_Valid) r_ser <= P_DATA;
        else if (Ser_EN)            r_ser <= {1'b0, r_ser[7:1]};
    end
    assign Ser_data = r_ser[0];

    // Observed cycle: {Busy, Ser_EN, Mux_sel, TX_OUT}
    localparam logic [4:0] c_IDLE_CYC = {1'b0, 1'b0, 2'b01, 1'b1};

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {Busy, Ser_EN, Mux_sel, TX_OUT};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={busy,ser_en,sel,tx}=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Run one frame. Called at a negedge with the DUT idle. perturb scrambles
    // inputs mid-frame; hold keeps Data_Valid high through the trailing idle.
    task automatic run_frame(input string name, input logic [7:0] d,
                             input logic pe, input logic pt, input logic s2,
                             input bit perturb, input bit hold);
        logic [4:0] q[$];
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Data_Valid = 1'b1;
        q.push_back({1'b1, 1'b0, 2'b00, 1'b0});
        for (int i = 0; i < 8; i++) q.push_back({1'b1, 1'b1, 2'b10, d[i]});
        if (pe) q.push_back({1'b1, 1'b0, 2'b11, (^d) ^ pt});
        q.push_back({1'b1, 1'b0, 2'b01, 1'b1});
        if (s2) q.push_back({1'b1, 1'b0, 2'b01, 1'b1});
        for (int i = 0; i < q.size(); i++) begin
            @(negedge CLK);
            check($sformatf("%s[%0d]", name, i), q[i]);
            if (perturb) begin
                P_DATA = 8'($urandom); PAR_EN = 1'($urandom);
                PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
                Data_Valid = 1'($urandom);
            end else if (!hold) begin
                Data_Valid = 1'b0;
            end
            if (i == q.size() - 1) Data_Valid = hold;
        end
        @(negedge CLK);
        check($sformatf("%s_idle", name), c_IDLE_CYC);
    endtask

    initial begin
        RST = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        #1 check("reset_async", c_IDLE_CYC);
        repeat (2) @(negedge CLK);
        check("reset_hold", c_IDLE_CYC);
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_idle", c_IDLE_CYC);

        // 1: basic frame, no parity, one stop
        run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 2: parity even / odd
        run_frame("07e", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame("07o", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // 3: odd parity on zero word, two stop bits
        run_frame("00o2", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // 4: Data_Valid held high, back-to-back frames, mid-frame input noise
        run_frame("hold0", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame("hold1", 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        run_frame("hold2", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        Data_Valid = 1'b0;
        @(negedge CLK);
        check("hold_end_idle", c_IDLE_CYC);

        // 5: reset during the 4th data bit, then a clean 0xFF frame
        P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b1;
        Data_Valid = 1'b1;
        @(negedge CLK);
        check("rst_start", {1'b1, 1'b0, 2'b00, 1'b0});
        Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_d3", {1'b1, 1'b1, 2'b10, 1'b0});
        #2 RST = 1'b1;
        #1 check("rst_midframe_async", c_IDLE_CYC);
        @(negedge CLK);
        check("rst_midframe_held", c_IDLE_CYC);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_release_idle", c_IDLE_CYC);
        run_frame("ff", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 6: random sweep with random idle gaps
        for (int n = 0; n < 40; n++) begin
            int gap;
            run_frame($sformatf("rnd%0d", n), 8'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'b1, 1'b0);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                check($sformatf("rnd%0d_gap", n), c_IDLE_CYC);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
